// File: rtl/ofdm_pkg.sv
// Shared OFDM subcarrier constants, buffer/reader state types and the
// data-index to IFFT-bin mapping used by the pilot inserter.
package ofdm_pkg;

  localparam int unsigned N_FFT  = 64;
  localparam int unsigned N_DATA = 48;
  localparam int unsigned KW     = 6;

  localparam logic [KW-1:0] LAST_DATA = KW'(N_DATA - 1);
  localparam logic [KW-1:0] LAST_BIN  = KW'(N_FFT - 1);

  // Bin 0 (DC) and the guard band 27..37 carry nothing
  localparam logic [KW-1:0] NULL_LO = 6'd27;
  localparam logic [KW-1:0] NULL_HI = 6'd37;

  localparam logic [KW-1:0] PILOT_K0 = 6'd7;
  localparam logic [KW-1:0] PILOT_K1 = 6'd21;
  localparam logic [KW-1:0] PILOT_K2 = 6'd43;
  localparam logic [KW-1:0] PILOT_K3 = 6'd57;
  // Bit i set means pilot i has base value -1
  localparam logic [3:0]    PILOT_BASE_NEG = 4'b0010;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_e;

  function automatic logic [KW-1:0] data2bin(input logic [KW-1:0] d);
    logic [KW-1:0] k;
    if (d <= 6'd4)       k = d + 6'd38;
    else if (d <= 6'd17) k = d + 6'd39;
    else if (d <= 6'd23) k = d + 6'd40;
    else if (d <= 6'd29) k = d - 6'd23;
    else if (d <= 6'd42) k = d - 6'd22;
    else                 k = d - 6'd21;
    return k;
  endfunction

  function automatic logic is_null(input logic [KW-1:0] k);
    return (k == '0) || ((k >= NULL_LO) && (k <= NULL_HI));
  endfunction

  // Returns {is_pilot, base_is_negative}
  function automatic logic [1:0] pilot_of(input logic [KW-1:0] k);
    logic [1:0] r;
    r = 2'b00;
    if (k == PILOT_K0) r = {1'b1, PILOT_BASE_NEG[0]};
    if (k == PILOT_K1) r = {1'b1, PILOT_BASE_NEG[1]};
    if (k == PILOT_K2) r = {1'b1, PILOT_BASE_NEG[2]};
    if (k == PILOT_K3) r = {1'b1, PILOT_BASE_NEG[3]};
    return r;
  endfunction

endpackage

// File: rtl/pilot_polarity_lfsr.sv
// Per-symbol pilot polarity: 7-bit LFSR (x^7 + x^4 + 1), seeded all-ones,
// p_neg is the feedback bit of the current state and steps on advance.
module pilot_polarity_lfsr (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic p_neg
);

  logic [6:0] s;

  assign p_neg = s[6] ^ s[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= 7'h7F;
    end else if (advance) begin
      s <= {s[5:0], p_neg};
    end
  end

endmodule

// File: rtl/pilot_insert.sv
// Collects 48 mapped data symbols per OFDM symbol into a ping-pong buffer and
// streams 64 IFFT bins in natural order with scrambled pilots and nulls inserted.
module pilot_insert
  import ofdm_pkg::*;
#(
  parameter int unsigned           W         = 16,
  parameter logic signed [W-1:0]   PILOT_AMP = W'(16'sd8192)
) (
  input  logic          pi_clk,
  input  logic          pi_rst,
  input  logic          din_valid,
  input  logic [W-1:0]  din_real,
  input  logic [W-1:0]  din_imag,
  input  logic [5:0]    din_index,
  output logic          din_ready,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [W-1:0]  dout_real,
  output logic [W-1:0]  dout_imag,
  output logic [5:0]    dout_index,
  output logic          dout_last,
  output logic          overflow,
  output logic          idx_err
);

  localparam int unsigned DW = 2 * W;
  localparam int unsigned AW = KW + 1;
  localparam logic [W-1:0] AMP_POS = PILOT_AMP;
  localparam logic [W-1:0] AMP_NEG = W'(-PILOT_AMP);

  logic [DW-1:0] mem [2*N_FFT];
  logic [DW-1:0] rd_data;

  bank_state_e bank_state [2];
  bank_state_e bank_nx    [2];
  logic        wr_bank;
  logic        in_range;
  logic        wr_en;
  logic        wr_last;
  logic [KW-1:0] wr_k;

  rd_state_e   rd_state, rd_state_nx;
  logic        rd_bank, rd_bank_nx;
  logic [KW-1:0] rd_k, rd_k_nx;
  logic        rd_en;
  logic        rd_start;
  logic [AW-1:0] rd_addr;

  logic        advance;
  logic        s1_valid;
  logic [KW-1:0] s1_k;
  logic        s1_bank;
  logic        out_bank;
  logic        out_done;
  logic        p_neg;
  logic [1:0]  pil;
  logic [W-1:0] bin_real, bin_imag;

  assign din_ready = (bank_state[wr_bank] == BANK_EMPTY) ||
                     (bank_state[wr_bank] == BANK_FILLING);
  assign in_range  = (din_index <= LAST_DATA);
  assign wr_en     = din_valid && din_ready && in_range;
  assign wr_last   = (din_index == LAST_DATA);
  assign wr_k      = data2bin(din_index);

  // The whole read pipeline moves only when the output slot is free or taken
  assign advance  = !dout_valid || dout_ready;
  assign out_done = dout_valid && dout_ready && dout_last;

  pilot_polarity_lfsr u_lfsr (
    .clk     (pi_clk),
    .rst     (pi_rst),
    .advance (out_done),
    .p_neg   (p_neg)
  );

  // Bank RAM: one write port from the mapper, one synchronous read port
  always_ff @(posedge pi_clk) begin
    if (wr_en) mem[{wr_bank, wr_k}] <= {din_real, din_imag};
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Writer, release and reader transitions never hit the same bank at once
  always_comb begin
    bank_nx = bank_state;
    if (out_done) bank_nx[out_bank] = BANK_EMPTY;
    if (rd_start) bank_nx[rd_bank]  = BANK_DRAINING;
    if (wr_en)    bank_nx[wr_bank]  = wr_last ? BANK_FULL : BANK_FILLING;
  end

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      bank_state <= '{BANK_EMPTY, BANK_EMPTY};
      wr_bank    <= 1'b0;
      overflow   <= 1'b0;
      idx_err    <= 1'b0;
    end else begin
      bank_state <= bank_nx;
      if (wr_en && wr_last)         wr_bank  <= !wr_bank;
      if (din_valid && !din_ready)  overflow <= 1'b1;
      if (din_valid && !in_range)   idx_err  <= 1'b1;
    end
  end

  // Reader: IDLE issues k=0 of a FULL bank directly so banks chain without a gap
  always_comb begin
    rd_state_nx = rd_state;
    rd_bank_nx  = rd_bank;
    rd_k_nx     = rd_k;
    rd_en       = 1'b0;
    rd_start    = 1'b0;
    rd_addr     = {rd_bank, rd_k};
    case (rd_state)
      RD_IDLE: begin
        if (advance && (bank_state[rd_bank] == BANK_FULL)) begin
          rd_en       = 1'b1;
          rd_start    = 1'b1;
          rd_addr     = {rd_bank, 6'd0};
          rd_k_nx     = 6'd1;
          rd_state_nx = RD_READ;
        end
      end
      RD_READ: begin
        if (advance) begin
          rd_en   = 1'b1;
          rd_k_nx = rd_k + 6'd1;
          if (rd_k == LAST_BIN) begin
            rd_bank_nx  = !rd_bank;
            rd_state_nx = RD_IDLE;
          end
        end
      end
      default: rd_state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_k     <= '0;
    end else begin
      rd_state <= rd_state_nx;
      rd_bank  <= rd_bank_nx;
      rd_k     <= rd_k_nx;
    end
  end

  // Bin value: null, scrambled pilot, or the stored data symbol
  always_comb begin
    pil      = pilot_of(s1_k);
    bin_real = rd_data[DW-1:W];
    bin_imag = rd_data[W-1:0];
    if (is_null(s1_k)) begin
      bin_real = '0;
      bin_imag = '0;
    end else if (pil[1]) begin
      bin_real = (pil[0] ^ p_neg) ? AMP_NEG : AMP_POS;
      bin_imag = '0;
    end
  end

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      s1_valid   <= 1'b0;
      s1_k       <= '0;
      s1_bank    <= 1'b0;
      dout_valid <= 1'b0;
      dout_real  <= '0;
      dout_imag  <= '0;
      dout_index <= '0;
      dout_last  <= 1'b0;
      out_bank   <= 1'b0;
    end else if (advance) begin
      s1_valid   <= rd_en;
      s1_k       <= rd_addr[KW-1:0];
      s1_bank    <= rd_addr[AW-1];
      dout_valid <= s1_valid;
      if (s1_valid) begin
        dout_real  <= bin_real;
        dout_imag  <= bin_imag;
        dout_index <= s1_k;
        dout_last  <= (s1_k == LAST_BIN);
        out_bank   <= s1_bank;
      end
    end
  end

endmodule

// File: tb/tb_pilot_insert.sv
// Directed bench for pilot_insert: spot-value table, full-symbol model compare,
// pilot polarity sequence, back-pressure, overflow and reset corner cases.
module tb_pilot_insert;

  logic               clk = 1'b0;
  logic               pi_rst = 1'b0;
  logic               din_valid = 1'b0;
  logic signed [15:0] din_real = '0;
  logic signed [15:0] din_imag = '0;
  logic [5:0]         din_index = '0;
  logic               din_ready;
  logic               dout_valid;
  logic               dout_ready = 1'b0;
  logic signed [15:0] dout_real;
  logic signed [15:0] dout_imag;
  logic [5:0]         dout_index;
  logic               dout_last;
  logic               overflow;
  logic               idx_err;

  pilot_insert dut (
    .pi_clk     (clk),
    .pi_rst     (pi_rst),
    .din_valid  (din_valid),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .din_index  (din_index),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag),
    .dout_index (dout_index),
    .dout_last  (dout_last),
    .overflow   (overflow),
    .idx_err    (idx_err)
  );

  always #5 clk = ~clk;

  typedef struct { int k; int re; int im; bit last; int cyc; } bin_t;
  typedef struct { int k; int re; int im; bit last; } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bin_t  got[$];
  int    b2d[64];
  bit    pol_neg[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
  bit    bp_en = 1'b0;
  bit    stalled = 1'b0;
  longint hold_val = 0;
  vec_t  spot[14];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) if (bp_en) begin
    #1;
    dout_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: records accepted bins and checks outputs hold while stalled
  always @(negedge clk) begin
    if (pi_rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("hold", longint'({dout_valid, dout_index, dout_last, dout_real, dout_imag}), hold_val);
      if (dout_valid && dout_ready)
        got.push_back('{k: int'(dout_index), re: int'(dout_real), im: int'(dout_imag),
                        last: dout_last, cyc: cyc});
      stalled  = dout_valid && !dout_ready;
      hold_val = longint'({dout_valid, dout_index, dout_last, dout_real, dout_imag});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    pi_rst = 1'b1;
    repeat (2) tick();
    pi_rst = 1'b0;
    got.delete();
    tick();
  endtask

  function automatic int pat(input int sym, input int d);
    return sym * 256 + d;
  endfunction

  task automatic send(input int d, input int re, input int im, input int gap);
    din_valid = 1'b1;
    din_index = 6'(d);
    din_real  = 16'(re);
    din_imag  = 16'(im);
    tick();
    din_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic send_sym(input int sym, input int gap);
    for (int d = 0; d < 48; d++) send(d, pat(sym, d), -pat(sym, d), gap);
  endtask

  task automatic wait_bins(input int n, input int budget, input string name);
    int c = 0;
    while (got.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(name, got.size(), n);
  endtask

  function automatic void exp_bin(input int k, input int sym, input bit pneg,
                                  output int re, output int im);
    if (k == 0 || (k >= 27 && k <= 37)) begin
      re = 0; im = 0;
    end else if (k == 7 || k == 21 || k == 43 || k == 57) begin
      re = (((k == 21) ? 1'b1 : 1'b0) ^ pneg) ? -8192 : 8192;
      im = 0;
    end else begin
      re = pat(sym, b2d[k]);
      im = -re;
    end
  endfunction

  task automatic check_symbol(input int sym, input bit pneg, input string name);
    bin_t b;
    int er, ei;
    for (int i = 0; i < 64; i++) begin
      if (got.size() == 0) begin
        check($sformatf("%s_missing_k%0d", name, i), 0, 1);
        return;
      end
      b = got.pop_front();
      exp_bin(i, sym, pneg, er, ei);
      check($sformatf("%s_k%0d_index", name, i), b.k, i);
      check($sformatf("%s_k%0d_re", name, i), b.re, er);
      check($sformatf("%s_k%0d_im", name, i), b.im, ei);
      check($sformatf("%s_k%0d_last", name, i), b.last, (i == 63) ? 1 : 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, nl;
    vec_t v;

    // Bench-side bin map: data fills 38..63 then 1..26, skipping pilots
    for (int k = 0; k < 64; k++) b2d[k] = -1;
    d = 0;
    for (int k = 38; k < 64; k++) if (k != 43 && k != 57) begin b2d[k] = d; d++; end
    for (int k = 1; k < 27; k++)  if (k != 7 && k != 21)  begin b2d[k] = d; d++; end

    spot[0]  = '{0, 0, 0, 0};       spot[1]  = '{1, 24, -24, 0};
    spot[2]  = '{6, 29, -29, 0};    spot[3]  = '{7, 8192, 0, 0};
    spot[4]  = '{20, 42, -42, 0};   spot[5]  = '{21, -8192, 0, 0};
    spot[6]  = '{26, 47, -47, 0};   spot[7]  = '{27, 0, 0, 0};
    spot[8]  = '{37, 0, 0, 0};      spot[9]  = '{38, 0, 0, 0};
    spot[10] = '{42, 4, -4, 0};     spot[11] = '{44, 5, -5, 0};
    spot[12] = '{57, 8192, 0, 0};   spot[13] = '{63, 23, -23, 1};

    // Reset values
    pi_rst = 1'b1;
    tick();
    check("rst_din_ready", din_ready, 1);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_real", dout_real, 0);
    check("rst_dout_index", dout_index, 0);
    check("rst_dout_last", dout_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_idx_err", idx_err, 0);
    do_reset();

    // Sequential input, one symbol every 4 clocks, with first-bin latency
    dout_ready = 1'b1;
    for (int i = 0; i < 47; i++) send(i, i, -i, 4);
    din_valid = 1'b1; din_index = 6'd47; din_real = 16'sd47; din_imag = -16'sd47;
    tick();
    din_valid = 1'b0;
    check("lat_c0_valid", dout_valid, 0);
    tick();
    check("lat_c1_valid", dout_valid, 0);
    tick();
    check("lat_c2_valid", dout_valid, 1);
    check("lat_c2_index", dout_index, 0);
    wait_bins(64, 200, "seq_wait");
    if (got.size() >= 64) begin
      for (int i = 0; i < 14; i++) begin
        v = spot[i];
        check($sformatf("spot_k%0d_re", v.k), got[v.k].re, v.re);
        check($sformatf("spot_k%0d_im", v.k), got[v.k].im, v.im);
        check($sformatf("spot_k%0d_last", v.k), got[v.k].last, v.last);
      end
      check("seq_contiguous", got[63].cyc - got[0].cyc, 63);
      nl = 0;
      foreach (got[i]) if (got[i].last) nl++;
      check("seq_last_count", nl, 1);
    end
    check_symbol(0, 1'b0, "seq");

    // Pilot polarity over 8 symbols
    do_reset();
    dout_ready = 1'b1;
    for (int s = 0; s < 8; s++) send_sym(s, 2);
    wait_bins(512, 3000, "pol_wait");
    if (got.size() >= 512) check("pol_s5_k21", got[4 * 64 + 21].re, 8192);
    for (int s = 0; s < 8; s++) check_symbol(s, pol_neg[s], $sformatf("pol%0d", s));
    check("pol_overflow", overflow, 0);

    // Random back-pressure
    do_reset();
    bp_en = 1'b1;
    send_sym(20, 2);
    send_sym(21, 2);
    wait_bins(128, 3000, "bp_wait");
    bp_en = 1'b0;
    tick();
    tick();
    dout_ready = 1'b1;
    check_symbol(20, 1'b0, "bp0");
    check_symbol(21, 1'b0, "bp1");
    check("bp_overflow", overflow, 0);

    // Overflow: output blocked while three symbols arrive
    do_reset();
    dout_ready = 1'b0;
    send_sym(10, 1);
    check("ovf_ready_after_s1", din_ready, 1);
    for (int i = 0; i < 47; i++) send(i, pat(11, i), -pat(11, i), 1);
    check("ovf_ready_before_d47", din_ready, 1);
    check("ovf_flag_before", overflow, 0);
    send(47, pat(11, 47), -pat(11, 47), 1);
    check("ovf_ready_after_s2", din_ready, 0);
    send_sym(12, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_none_while_stalled", got.size(), 0);
    dout_ready = 1'b1;
    wait_bins(128, 400, "ovf_wait");
    if (got.size() >= 128) check("ovf_contiguous", got[127].cyc - got[0].cyc, 127);
    check_symbol(10, 1'b0, "ovf0");
    check_symbol(11, 1'b0, "ovf1");
    repeat (150) tick();
    check("ovf_extra_bins", got.size(), 0);
    check("ovf_sticky", overflow, 1);

    // Bad index, then reset in the middle of a symbol
    do_reset();
    dout_ready = 1'b1;
    send(50, 111, 222, 2);
    check("bad_idx_err", idx_err, 1);
    check("bad_din_ready", din_ready, 1);
    check("bad_overflow", overflow, 0);
    for (int i = 0; i <= 20; i++) send(i, pat(30, i), -pat(30, i), 2);
    check("part_no_output", got.size(), 0);
    pi_rst = 1'b1;
    #1;
    check("mid_rst_idx_err", idx_err, 0);
    check("mid_rst_dout_valid", dout_valid, 0);
    check("mid_rst_din_ready", din_ready, 1);
    check("mid_rst_overflow", overflow, 0);
    tick();
    pi_rst = 1'b0;
    got.delete();
    tick();
    send_sym(31, 4);
    wait_bins(64, 200, "rst_wait");
    check_symbol(31, 1'b0, "rst");
    repeat (100) tick();
    check("rst_extra_bins", got.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
